// File: rtl/thr_cal_ctrl_pkg.sv
// Shared types and sizing for the threshold calibration sequencer.
package thr_ctrl_pkg;

   localparam int NUM_CH = 35;
   localparam int CH_W   = 6;
   localparam int THR_W  = 16;
   localparam logic [THR_W-1:0] DEFAULT_THR = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM_RST,
      ST_ARM_WAIT,
      ST_RUN,
      ST_COMMIT
   } cal_state_e;

endpackage

// File: rtl/thr_cal_ctrl_if.sv
// Sample stream, calculator handshake, table read port and status of the sequencer.
interface thr_cal_ctrl_if;
   import thr_ctrl_pkg::*;

   logic             cal_req;
   logic             raw_data_valid;
   logic [CH_W-1:0]  channel;
   logic [15:0]      raw_data_in;
   logic             sample_valid_o;
   logic [15:0]      sample_o;
   logic             calc_rst_o;
   logic             threshold_v;
   logic [THR_W-1:0] threshold_i;
   logic [CH_W-1:0]  thr_rd_addr;
   logic [THR_W-1:0] thr_rd_data;
   logic             table_valid;
   logic             cal_busy;
   logic             cal_done;
   logic             cal_err;

   modport master (
      output cal_req, raw_data_valid, channel, raw_data_in, threshold_v, threshold_i, thr_rd_addr,
      input  sample_valid_o, sample_o, calc_rst_o, thr_rd_data, table_valid, cal_busy, cal_done, cal_err
   );

   modport slave (
      input  cal_req, raw_data_valid, channel, raw_data_in, threshold_v, threshold_i, thr_rd_addr,
      output sample_valid_o, sample_o, calc_rst_o, thr_rd_data, table_valid, cal_busy, cal_done, cal_err
   );

endinterface

// File: rtl/thr_cal_ctrl_bank.sv
// Double-buffered threshold table: writes land in the shadow bank, swap flips banks atomically.
module thr_bank
   import thr_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_addr,
   input  logic [THR_W-1:0] wr_data,
   input  logic             swap,
   input  logic [CH_W-1:0]  rd_addr,
   output logic [THR_W-1:0] rd_data
);

   logic [THR_W-1:0] mem_q [2][NUM_CH];
   logic [THR_W-1:0] mem_d [2][NUM_CH];
   logic             active_q, active_d;
   logic [THR_W-1:0] rd_data_q, rd_data_d;

   // The read uses the pre-swap bank, so a read coinciding with a swap returns old data.
   always_comb begin
      mem_d    = mem_q;
      active_d = active_q ^ swap;
      if (wr_en && (wr_addr < CH_W'(NUM_CH))) begin
         mem_d[~active_q][wr_addr] = wr_data;
      end
      if (rd_addr < CH_W'(NUM_CH)) begin
         rd_data_d = mem_q[active_q][rd_addr];
      end else begin
         rd_data_d = DEFAULT_THR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               mem_q[b][i] <= DEFAULT_THR;
            end
         end
         active_q  <= 1'b0;
         rd_data_q <= DEFAULT_THR;
      end else begin
         mem_q     <= mem_d;
         active_q  <= active_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/thr_cal_ctrl.sv
// Calibration sequencer: restarts the RMS threshold calculator on frame boundaries and
// publishes a complete threshold table per calibration through a double-buffered bank.
module thr_cal_ctrl
   import thr_ctrl_pkg::*;
#(
   parameter int WIN_FRAMES     = 1024,
   parameter int TIMEOUT_FRAMES = 2*WIN_FRAMES + 4,
   parameter int RECAL_FRAMES   = 0
) (
   input logic clk,
   input logic rst,
   thr_cal_ctrl_if.slave bus
);

   localparam int FC_W   = $clog2(TIMEOUT_FRAMES + 1);
   localparam int AUTO_W = (RECAL_FRAMES > 1) ? $clog2(RECAL_FRAMES) : 1;
   localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(TIMEOUT_FRAMES - 1);
   localparam logic [FC_W-1:0]   FC_SAT    = FC_W'(TIMEOUT_FRAMES);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'((RECAL_FRAMES > 0) ? RECAL_FRAMES - 1 : 0);
   localparam bit                AUTO_EN   = (RECAL_FRAMES > 0);

   cal_state_e        state_q, state_d;
   logic              pend_q, pend_d;
   logic              err_q, err_d;
   logic              tv_q, tv_d;
   logic              busy_q, busy_d;
   logic              calc_rst_q, calc_rst_d;
   logic              done_q, done_d;
   logic [CH_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

   logic frame_end;
   logic tick;
   logic last_strobe;
   logic wr_en;
   logic swap;

   assign frame_end   = bus.raw_data_valid && (bus.channel == CH_W'(NUM_CH - 1));
   assign tick        = AUTO_EN && (state_q == ST_IDLE) && frame_end && (auto_cnt_q == AUTO_LAST);
   assign last_strobe = bus.threshold_v && (wr_ptr_q == CH_W'(NUM_CH - 1));

   // The auto counter only runs while idle; any other state holds it at zero.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      err_d       = err_q;
      tv_d        = tv_q;
      wr_ptr_d    = wr_ptr_q;
      frame_cnt_d = frame_cnt_q;
      auto_cnt_d  = '0;
      wr_en       = 1'b0;
      swap        = 1'b0;

      if ((state_q != ST_IDLE) && bus.cal_req) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_end && !tick) begin
               auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end else if (!frame_end) begin
               auto_cnt_d = auto_cnt_q;
            end
            if (bus.cal_req || pend_q || tick) begin
               state_d    = ST_ARM_RST;
               pend_d     = 1'b0;
               err_d      = 1'b0;
               auto_cnt_d = '0;
            end
         end
         ST_ARM_RST: begin
            wr_ptr_d    = '0;
            frame_cnt_d = '0;
            state_d     = ST_ARM_WAIT;
         end
         ST_ARM_WAIT: begin
            if (bus.raw_data_valid && (bus.channel == '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.threshold_v) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + CH_W'(1);
            end
            if (last_strobe) begin
               state_d = ST_COMMIT;
            end else if (frame_end) begin
               if (frame_cnt_q == FC_LAST) begin
                  frame_cnt_d = FC_SAT;
                  err_d       = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  frame_cnt_d = frame_cnt_q + FC_W'(1);
               end
            end
         end
         ST_COMMIT: begin
            swap    = 1'b1;
            tv_d    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d     = (state_d != ST_IDLE);
      calc_rst_d = (state_d == ST_ARM_RST);
      done_d     = (state_d == ST_COMMIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
         tv_q        <= 1'b0;
         busy_q      <= 1'b0;
         calc_rst_q  <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         frame_cnt_q <= '0;
         auto_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         tv_q        <= tv_d;
         busy_q      <= busy_d;
         calc_rst_q  <= calc_rst_d;
         done_q      <= done_d;
         wr_ptr_q    <= wr_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         auto_cnt_q  <= auto_cnt_d;
      end
   end

   thr_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.threshold_i),
      .swap    (swap),
      .rd_addr (bus.thr_rd_addr),
      .rd_data (bus.thr_rd_data)
   );

   // The calculator only ever sees whole frames, starting from channel 0.
   assign bus.sample_valid_o = bus.raw_data_valid &&
                               ((state_q == ST_RUN) || ((state_q == ST_ARM_WAIT) && (bus.channel == '0)));
   assign bus.sample_o       = bus.raw_data_in;
   assign bus.calc_rst_o     = calc_rst_q;
   assign bus.table_valid    = tv_q;
   assign bus.cal_busy       = busy_q;
   assign bus.cal_done       = done_q;
   assign bus.cal_err        = err_q;

endmodule

// File: tb/tb_thr_cal_ctrl.sv
// Randomized bench for thr_cal_ctrl, checked every cycle against a job-level reference model.
module tb_thr_cal_ctrl;
   import thr_ctrl_pkg::*;

   localparam int WIN   = 8;
   localparam int TO    = 2*WIN + 4;
   localparam int RECAL = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   thr_cal_ctrl_if bus ();

   thr_cal_ctrl #(
      .WIN_FRAMES     (WIN),
      .TIMEOUT_FRAMES (TO),
      .RECAL_FRAMES   (RECAL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: one calibration "job" with a capture queue and a published table.
   bit               m_job, m_arming, m_synced, m_commit, m_pend, m_err, m_tv;
   int               m_frames, m_idle, m_commits;
   logic [THR_W-1:0] m_cap[$];
   logic [THR_W-1:0] m_tab[NUM_CH];
   logic [THR_W-1:0] m_rd;

   int               rv_pct = 85;
   int               thr_pct = 20;
   logic [THR_W-1:0] thr_base = '0;
   int               rd_mode = 0;
   logic [CH_W-1:0]  rd_fix = '0;
   int               cur_ch = 0;
   bit               last_fe = 1'b0;
   int               done_seen = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic boundFail(input string tag);
      n_checks++;
      $display("[TB] FAIL %s: wait bound expired at %0t", tag, $time);
   endtask

   task automatic modelReset();
      m_job = 0; m_arming = 0; m_synced = 0; m_commit = 0; m_pend = 0; m_err = 0; m_tv = 0;
      m_frames = 0; m_idle = 0;
      m_cap.delete();
      foreach (m_tab[i]) m_tab[i] = DEFAULT_THR;
      m_rd = DEFAULT_THR;
   endtask

   task automatic modelStep(input bit req, input bit rv, input int ch, input bit thv,
                            input logic [THR_W-1:0] thval, input int addr, input bit rs);
      bit fe;
      if (rs) begin
         modelReset();
         return;
      end
      fe   = rv && (ch == NUM_CH - 1);
      m_rd = (addr < NUM_CH) ? m_tab[addr] : DEFAULT_THR;
      if (!m_job) begin
         if (req || m_pend || (fe && m_idle == RECAL - 1)) begin
            m_job = 1; m_arming = 1; m_synced = 0; m_commit = 0;
            m_cap.delete();
            m_frames = 0; m_pend = 0; m_err = 0; m_idle = 0;
         end else if (fe) begin
            m_idle++;
         end
      end else begin
         m_idle = 0;
         if (req) m_pend = 1;
         if (m_commit) begin
            for (int i = 0; i < NUM_CH; i++) m_tab[i] = m_cap[i];
            m_tv = 1; m_commit = 0; m_job = 0;
            m_commits++;
         end else if (m_arming) begin
            m_arming = 0;
         end else if (!m_synced) begin
            if (rv && ch == 0) m_synced = 1;
         end else begin
            if (thv) m_cap.push_back(thval);
            if (m_cap.size() == NUM_CH) m_commit = 1;
            else if (fe) begin
               m_frames++;
               if (m_frames == TO) begin
                  m_err = 1;
                  m_job = 0;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit req, input bit rv, input bit thv, input logic [THR_W-1:0] thval,
                                input logic [CH_W-1:0] addr, input bit rs);
      logic [15:0] raw;
      bit          exp_sv;
      @(negedge clk);
      raw                = 16'($urandom);
      rst                = rs;
      bus.cal_req        = req;
      bus.raw_data_valid = rv;
      bus.channel        = CH_W'(cur_ch);
      bus.raw_data_in    = raw;
      bus.threshold_v    = thv;
      bus.threshold_i    = thval;
      bus.thr_rd_addr    = addr;
      #1;
      exp_sv = rv && m_job && !m_arming && !m_commit && (m_synced || cur_ch == 0);
      checkOutput("cal_busy", {31'd0, bus.cal_busy}, {31'd0, m_job});
      checkOutput("calc_rst_o", {31'd0, bus.calc_rst_o}, {31'd0, m_job && m_arming});
      checkOutput("cal_done", {31'd0, bus.cal_done}, {31'd0, m_commit});
      checkOutput("cal_err", {31'd0, bus.cal_err}, {31'd0, m_err});
      checkOutput("table_valid", {31'd0, bus.table_valid}, {31'd0, m_tv});
      checkOutput("thr_rd_data", {16'd0, bus.thr_rd_data}, {16'd0, m_rd});
      checkOutput("sample_valid_o", {31'd0, bus.sample_valid_o}, {31'd0, exp_sv});
      checkOutput("sample_o", {16'd0, bus.sample_o}, {16'd0, raw});
      if (bus.cal_done === 1'b1) done_seen++;
      modelStep(req, rv, cur_ch, thv, thval, int'(addr), rs);
      last_fe = rv && (cur_ch == NUM_CH - 1);
      if (rv) cur_ch = (cur_ch + 1) % NUM_CH;
   endtask

   task automatic runCycle(input bit req, input bit force_rv, input bit rs);
      bit               rv, thv;
      logic [THR_W-1:0] thval;
      logic [CH_W-1:0]  addr;
      rv    = force_rv || ($urandom_range(99) < rv_pct);
      thv   = ($urandom_range(99) < thr_pct);
      thval = (m_job && m_synced && !m_commit) ? thr_base + THR_W'(m_cap.size()) : THR_W'($urandom);
      addr  = (rd_mode == 1) ? rd_fix : CH_W'($urandom_range(63));
      applyStimulus(req, rv, thv, thval, addr, rs);
   endtask

   task automatic waitCommits(input int target, input string tag);
      int budget = 5000;
      while (m_commits < target && budget > 0) begin
         runCycle(0, 0, 0);
         budget--;
      end
      if (m_commits < target) boundFail(tag);
   endtask

   initial begin
      int c0, frames, pulses, budget;
      rst = 1'b1;
      bus.cal_req = 0; bus.raw_data_valid = 0; bus.channel = '0; bus.raw_data_in = '0;
      bus.threshold_v = 0; bus.threshold_i = '0; bus.thr_rd_addr = '0;
      m_commits = 0;
      modelReset();
      repeat (3) @(posedge clk);

      // Reset state: default table, no valid samples, stray strobes ignored.
      rd_mode = 1;
      for (int a = 0; a < 64; a++) begin
         rd_fix = CH_W'(a);
         runCycle(0, 0, 0);
         if (a > 0) checkOutput("rst_rd", {16'd0, bus.thr_rd_data}, 32'h0000FFFF);
         checkOutput("rst_sv", {31'd0, bus.sample_valid_o}, 32'd0);
      end

      // Basic calibration, requested mid-frame at channel 17.
      thr_base = 16'h8000; rd_mode = 0;
      for (int k = 0; k < 500 && cur_ch != 17; k++) runCycle(0, 0, 0);
      c0 = m_commits;
      runCycle(1, 1, 0);
      waitCommits(c0 + 1, "basic_wait");
      thr_pct = 0; rd_mode = 1;
      for (int a = 0; a <= NUM_CH; a++) begin
         rd_fix = CH_W'(a % NUM_CH);
         runCycle(0, 0, 0);
         if (a > 0) checkOutput("basic_rd", {16'd0, bus.thr_rd_data}, 32'h8000 + 32'(a - 1));
      end
      checkOutput("basic_tv", {31'd0, bus.table_valid}, 32'd1);

      // Atomic swap while reading channel 5.
      thr_pct = 20; thr_base = 16'h9000; rd_fix = CH_W'(5);
      c0 = m_commits;
      runCycle(1, 0, 0);
      waitCommits(c0 + 1, "swap_wait");
      thr_pct = 0;
      runCycle(0, 0, 0);
      checkOutput("swap_old", {16'd0, bus.thr_rd_data}, 32'h8005);
      runCycle(0, 0, 0);
      checkOutput("swap_new", {16'd0, bus.thr_rd_data}, 32'h9005);

      // Three requests during RUN give exactly one extra calibration.
      thr_pct = 20; thr_base = 16'hA000; rd_mode = 0;
      c0 = m_commits; done_seen = 0;
      runCycle(1, 0, 0);
      for (int k = 0; k < 500 && !(m_job && m_synced); k++) runCycle(0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         runCycle(1, 0, 0);
         runCycle(0, 0, 0);
      end
      waitCommits(c0 + 2, "pend_wait");
      runCycle(0, 0, 0);
      checkOutput("pend_done", 32'(done_seen), 32'd2);

      // Timeout with no strobes; table keeps the previous calibration.
      thr_pct = 0; rd_mode = 1; rd_fix = CH_W'(5);
      runCycle(1, 0, 0);
      budget = 3000;
      while (!m_err && budget > 0) begin
         runCycle(0, 0, 0);
         budget--;
      end
      if (!m_err) boundFail("to_wait");
      runCycle(0, 0, 0);
      checkOutput("to_err", {31'd0, bus.cal_err}, 32'd1);
      checkOutput("to_busy", {31'd0, bus.cal_busy}, 32'd0);
      checkOutput("to_tab", {16'd0, bus.thr_rd_data}, 32'hA005);
      runCycle(1, 0, 0);
      runCycle(0, 0, 0);
      checkOutput("to_clr", {31'd0, bus.cal_err}, 32'd0);

      // Auto recalibration starts RECAL frames after cal_done.
      thr_pct = 20; thr_base = 16'hB000; rd_mode = 0;
      budget = 5000;
      while (bus.cal_done !== 1'b1 && budget > 0) begin
         runCycle(0, 0, 0);
         budget--;
      end
      if (bus.cal_done !== 1'b1) boundFail("auto_done_wait");
      frames = 0; budget = 2000;
      while (budget > 0) begin
         runCycle(0, 0, 0);
         if (bus.calc_rst_o === 1'b1) break;
         if (last_fe) frames++;
         budget--;
      end
      checkOutput("auto_frames", 32'(frames), 32'(RECAL));

      // Request coincident with the auto tick starts a single calibration.
      budget = 5000;
      while (!(!m_job && m_idle == RECAL - 1 && cur_ch == NUM_CH - 1) && budget > 0) begin
         runCycle(0, 0, 0);
         budget--;
      end
      if (budget == 0) boundFail("coinc_wait");
      runCycle(1, 1, 0);
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         runCycle(0, 0, 0);
         if (bus.calc_rst_o === 1'b1) pulses++;
      end
      checkOutput("coinc_rst", 32'(pulses), 32'd1);

      // Reset in the middle of RUN clears the tables.
      budget = 5000;
      while (!(m_job && m_synced && m_cap.size() > 5) && budget > 0) begin
         runCycle(0, 0, 0);
         budget--;
      end
      if (budget == 0) boundFail("rst_run_wait");
      runCycle(0, 0, 1);
      thr_pct = 0; rd_mode = 1;
      for (int a = 0; a <= NUM_CH; a++) begin
         rd_fix = CH_W'(a % NUM_CH);
         runCycle(0, 0, 0);
         if (a > 0) checkOutput("rst_run_rd", {16'd0, bus.thr_rd_data}, 32'h0000FFFF);
      end
      checkOutput("rst_run_tv", {31'd0, bus.table_valid}, 32'd0);

      // Free-running random mix.
      thr_pct = 25; rd_mode = 0; thr_base = 16'hC000;
      for (int k = 0; k < 3000; k++) begin
         runCycle($urandom_range(99) < 2, 0, $urandom_range(999) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
